// File: rtl/pipe_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package pipe_pkg;

  // Widest register index the tracking slots can hold; RB must not exceed this.
  localparam int unsigned RB_MAX = 8;

  // Operand source select encoding shared by the EX and ID forwarding muxes.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic [RB_MAX-1:0] dest;
    logic              is_load;
  } slot_t;

  // MEM wins over WB; a load still in MEM has no data to forward yet.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic mem_is_load,
                                         input logic wb_hit);
    if (mem_hit && !mem_is_load) begin
      return FWD_MEM;
    end else if (wb_hit) begin
      return FWD_WB;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hz_match.sv
// Compares one tracked producer against one source operand index.
module hz_match
  import pipe_pkg::*;
#(
  parameter int unsigned RB = 5
) (
  input  logic              valid_i,
  input  logic              wr_en_i,
  input  logic [RB_MAX-1:0] dest_i,
  input  logic [RB-1:0]     src_i,
  input  logic              use_i,
  output logic              match_o
);

  logic [RB_MAX-1:0] src_ext;

  // Register 0 is hardwired, so a write to it never produces a dependency.
  always_comb begin
    src_ext = RB_MAX'(src_i);
    match_o = valid_i & wr_en_i & use_i & (dest_i != '0) & (dest_i == src_ext);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for a 5-stage MIPS pipeline.
// Optional performance counters are built when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned RB      = 5,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RB-1:0] id_rs,
  input  logic [RB-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wr_en,
  input  logic [RB-1:0] id_dest,
  input  logic          id_is_load,
  input  logic          id_is_branch,
  input  logic          id_redirect,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic          pipe_hold,
  output logic [1:0]    fwd_a_ex,
  output logic [1:0]    fwd_b_ex,
  output logic [1:0]    fwd_a_id,
  output logic [1:0]    fwd_b_id
`ifdef HAZ_PERF_EN
  ,
  output logic [CW-1:0] perf_stall,
  output logic [CW-1:0] perf_flush
`endif
);

  localparam logic [3:0] MemCntInit = 4'(MEM_LAT - 1);

  slot_t             ex_q, ex_d, mem_q, mem_d;
  // WB only needs producer identity; its load flag no longer matters.
  logic              wb_valid_q, wb_valid_d, wb_wr_en_q, wb_wr_en_d;
  logic [RB_MAX-1:0] wb_dest_q, wb_dest_d;
  logic [RB-1:0]     ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic              ex_use_rs_q, ex_use_rs_d, ex_use_rt_q, ex_use_rt_d;
  logic [3:0]        mem_cnt_q, mem_cnt_d;

  logic ex_hit_rs, ex_hit_rt;
  logic mem_hit_id_rs, mem_hit_id_rt, mem_hit_ex_rs, mem_hit_ex_rt;
  logic wb_hit_id_rs, wb_hit_id_rt, wb_hit_ex_rs, wb_hit_ex_rt;
  logic hz;

  hz_match #(.RB(RB)) u_ex_id_rs (.valid_i(ex_q.valid), .wr_en_i(ex_q.wr_en),
    .dest_i(ex_q.dest), .src_i(id_rs), .use_i(id_use_rs), .match_o(ex_hit_rs));
  hz_match #(.RB(RB)) u_ex_id_rt (.valid_i(ex_q.valid), .wr_en_i(ex_q.wr_en),
    .dest_i(ex_q.dest), .src_i(id_rt), .use_i(id_use_rt), .match_o(ex_hit_rt));
  hz_match #(.RB(RB)) u_mem_id_rs (.valid_i(mem_q.valid), .wr_en_i(mem_q.wr_en),
    .dest_i(mem_q.dest), .src_i(id_rs), .use_i(id_use_rs), .match_o(mem_hit_id_rs));
  hz_match #(.RB(RB)) u_mem_id_rt (.valid_i(mem_q.valid), .wr_en_i(mem_q.wr_en),
    .dest_i(mem_q.dest), .src_i(id_rt), .use_i(id_use_rt), .match_o(mem_hit_id_rt));
  hz_match #(.RB(RB)) u_mem_ex_rs (.valid_i(mem_q.valid), .wr_en_i(mem_q.wr_en),
    .dest_i(mem_q.dest), .src_i(ex_rs_q), .use_i(ex_use_rs_q), .match_o(mem_hit_ex_rs));
  hz_match #(.RB(RB)) u_mem_ex_rt (.valid_i(mem_q.valid), .wr_en_i(mem_q.wr_en),
    .dest_i(mem_q.dest), .src_i(ex_rt_q), .use_i(ex_use_rt_q), .match_o(mem_hit_ex_rt));
  hz_match #(.RB(RB)) u_wb_id_rs (.valid_i(wb_valid_q), .wr_en_i(wb_wr_en_q),
    .dest_i(wb_dest_q), .src_i(id_rs), .use_i(id_use_rs), .match_o(wb_hit_id_rs));
  hz_match #(.RB(RB)) u_wb_id_rt (.valid_i(wb_valid_q), .wr_en_i(wb_wr_en_q),
    .dest_i(wb_dest_q), .src_i(id_rt), .use_i(id_use_rt), .match_o(wb_hit_id_rt));
  hz_match #(.RB(RB)) u_wb_ex_rs (.valid_i(wb_valid_q), .wr_en_i(wb_wr_en_q),
    .dest_i(wb_dest_q), .src_i(ex_rs_q), .use_i(ex_use_rs_q), .match_o(wb_hit_ex_rs));
  hz_match #(.RB(RB)) u_wb_ex_rt (.valid_i(wb_valid_q), .wr_en_i(wb_wr_en_q),
    .dest_i(wb_dest_q), .src_i(ex_rt_q), .use_i(ex_use_rt_q), .match_o(wb_hit_ex_rt));

  // Stall/flush/forward decisions from tracked state and the ID instruction only.
  always_comb begin
    pipe_hold   = (mem_cnt_q != 4'd0);
    hz          = id_valid & ((ex_q.is_load & (ex_hit_rs | ex_hit_rt))
                | (id_is_branch & (ex_hit_rs | ex_hit_rt))
                | (id_is_branch & mem_q.is_load & (mem_hit_id_rs | mem_hit_id_rt)));
    pc_en       = ~(hz | pipe_hold);
    ifid_en     = ~(hz | pipe_hold);
    idex_bubble = hz & ~pipe_hold;
    ifid_flush  = id_redirect & id_valid & ~hz & ~pipe_hold;
    fwd_a_ex    = fwd_sel(mem_hit_ex_rs, mem_q.is_load, wb_hit_ex_rs);
    fwd_b_ex    = fwd_sel(mem_hit_ex_rt, mem_q.is_load, wb_hit_ex_rt);
    fwd_a_id    = fwd_sel(mem_hit_id_rs, mem_q.is_load, wb_hit_id_rs);
    fwd_b_id    = fwd_sel(mem_hit_id_rt, mem_q.is_load, wb_hit_id_rt);
  end

  // Slot advance: frozen under hold (WB takes a bubble), else shift with ID entering EX.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_valid_d  = 1'b0;
    wb_wr_en_d  = wb_wr_en_q;
    wb_dest_d   = wb_dest_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_use_rs_d = ex_use_rs_q;
    ex_use_rt_d = ex_use_rt_q;
    mem_cnt_d   = mem_cnt_q;
    if (!pipe_hold) begin
      wb_valid_d   = mem_q.valid;
      wb_wr_en_d   = mem_q.wr_en;
      wb_dest_d    = mem_q.dest;
      mem_d        = ex_q;
      ex_d.valid   = id_valid & ~hz;
      ex_d.wr_en   = id_wr_en;
      ex_d.dest    = RB_MAX'(id_dest);
      ex_d.is_load = id_is_load;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;
      // A bubble reads nothing, so it never requests forwarding.
      ex_use_rs_d  = id_use_rs & id_valid & ~hz;
      ex_use_rt_d  = id_use_rt & id_valid & ~hz;
    end
    if (!pipe_hold && ex_q.valid && ex_q.is_load) begin
      mem_cnt_d = MemCntInit;
    end else if (mem_cnt_q != 4'd0) begin
      mem_cnt_d = mem_cnt_q - 4'd1;
    end
  end

  // Tracking state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_wr_en_q  <= 1'b0;
      wb_dest_q   <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
      mem_cnt_q   <= 4'd0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_valid_q  <= wb_valid_d;
      wb_wr_en_q  <= wb_wr_en_d;
      wb_dest_q   <= wb_dest_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_use_rs_q <= ex_use_rs_d;
      ex_use_rt_q <= ex_use_rt_d;
      mem_cnt_q   <= mem_cnt_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic [CW-1:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  // Saturating event counters.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (!pc_en && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + CW'(1);
    if (ifid_flush && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + CW'(1);
    perf_stall = perf_stall_q;
    perf_flush = perf_flush_q;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-by-cycle instruction trace on a
// single-cycle-memory instance plus hand sequences on a MEM_LAT=3 instance.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_is_branch, id_redirect;
  logic [4:0] id_rs, id_rt, id_dest;

  logic       pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold;
  logic [1:0] fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id;
  logic       u3_pc_en, u3_ifid_en, u3_ifid_flush, u3_idex_bubble, u3_pipe_hold;
  logic [1:0] u3_fwd_a_ex, u3_fwd_b_ex, u3_fwd_a_id, u3_fwd_b_id;
`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall, perf_flush, u3_perf_stall, u3_perf_flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RB(5), .MEM_LAT(1), .CW(32)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_dest(id_dest),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_redirect(id_redirect),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_hold(pipe_hold), .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex), .fwd_a_id(fwd_a_id),
    .fwd_b_id(fwd_b_id)
`ifdef HAZ_PERF_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  pipe_hazard_ctrl #(.RB(5), .MEM_LAT(3), .CW(32)) u_dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_dest(id_dest),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_redirect(id_redirect),
    .pc_en(u3_pc_en), .ifid_en(u3_ifid_en), .ifid_flush(u3_ifid_flush),
    .idex_bubble(u3_idex_bubble), .pipe_hold(u3_pipe_hold), .fwd_a_ex(u3_fwd_a_ex),
    .fwd_b_ex(u3_fwd_b_ex), .fwd_a_id(u3_fwd_a_id), .fwd_b_id(u3_fwd_b_id)
`ifdef HAZ_PERF_EN
    , .perf_stall(u3_perf_stall), .perf_flush(u3_perf_flush)
`endif
  );

  typedef struct {
    logic       val;
    logic [4:0] rs, rt;
    logic       urs, urt, wr;
    logic [4:0] dest;
    logic       ld, br, rd;
    logic       pc, bub, fl;
    logic [1:0] fae, fbe, fai, fbi;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input int val, input int rs, input int rt, input int urs,
                              input int urt, input int wr, input int dest, input int ld,
                              input int br, input int rd, input int pc, input int bub,
                              input int fl, input int fae, input int fbe, input int fai,
                              input int fbi);
    vec_t r;
    r.val = 1'(val);  r.rs  = 5'(rs);   r.rt  = 5'(rt);   r.urs = 1'(urs);
    r.urt = 1'(urt);  r.wr  = 1'(wr);   r.dest = 5'(dest); r.ld = 1'(ld);
    r.br  = 1'(br);   r.rd  = 1'(rd);   r.pc  = 1'(pc);   r.bub = 1'(bub);
    r.fl  = 1'(fl);   r.fae = 2'(fae);  r.fbe = 2'(fbe);  r.fai = 2'(fai);
    r.fbi = 2'(fbi);
    return r;
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.val;  id_rs = v.rs;  id_rt = v.rt;  id_use_rs = v.urs;
    id_use_rt = v.urt; id_wr_en = v.wr; id_dest = v.dest; id_is_load = v.ld;
    id_is_branch = v.br; id_redirect = v.rd;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ID inputs                               | expected pc bub fl  fae fbe fai fbi
    tbl[0]  = mk(1, 1, 2, 1, 0, 1, 2, 1, 0, 0,    1, 0, 0, 0, 0, 0, 0); // lw $2 (reset state)
    tbl[1]  = mk(1, 2, 4, 1, 1, 1, 3, 0, 0, 0,    0, 1, 0, 0, 0, 0, 0); // add $3,$2,$4 load-use
    tbl[2]  = mk(1, 2, 4, 1, 1, 1, 3, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0); // add retried
    tbl[3]  = mk(1, 6, 7, 1, 1, 1, 5, 0, 0, 0,    1, 0, 0, 2, 0, 0, 0); // add $5; EX gets WB data
    tbl[4]  = mk(1, 5, 3, 1, 1, 1, 8, 0, 0, 0,    1, 0, 0, 0, 0, 0, 1); // sub $8,$5,$3
    tbl[5]  = mk(1, 5, 0, 1, 1, 1, 9, 0, 0, 0,    1, 0, 0, 1, 2, 1, 0); // or $9,$5,$0
    tbl[6]  = mk(1, 8, 8, 1, 1, 1, 0, 0, 0, 0,    1, 0, 0, 2, 0, 1, 1); // add $0,$8,$8
    tbl[7]  = mk(1, 0, 0, 1, 1, 1, 10, 0, 0, 0,   1, 0, 0, 2, 2, 0, 0); // add $10,$0,$0
    tbl[8]  = mk(1, 0, 9, 1, 1, 0, 0, 0, 1, 0,    1, 0, 0, 0, 0, 0, 2); // beq $0,$9 (not taken)
    tbl[9]  = mk(1, 1, 1, 1, 1, 1, 6, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0); // add $6,$1,$1
    tbl[10] = mk(1, 6, 2, 1, 1, 0, 0, 0, 1, 1,    0, 1, 0, 0, 0, 0, 0); // beq $6 taken: stall
    tbl[11] = mk(1, 6, 2, 1, 1, 0, 0, 0, 1, 1,    1, 0, 1, 0, 0, 1, 0); // resolves, flush
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 2, 0, 0, 0); // flushed slot
    tbl[13] = mk(1, 3, 7, 1, 0, 1, 7, 1, 0, 0,    1, 0, 0, 0, 0, 0, 0); // lw $7
    tbl[14] = mk(1, 7, 0, 1, 1, 0, 0, 0, 1, 1,    0, 1, 0, 0, 0, 0, 0); // beq $7: load in EX
    tbl[15] = mk(1, 7, 0, 1, 1, 0, 0, 0, 1, 1,    0, 1, 0, 0, 0, 0, 0); // load in MEM
    tbl[16] = mk(1, 7, 0, 1, 1, 0, 0, 0, 1, 1,    1, 0, 1, 0, 0, 2, 0); // resolves from WB

    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("trace%0d", i),
            32'({pc_en, ifid_en, idex_bubble, ifid_flush, pipe_hold,
                 fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id}),
            32'({tbl[i].pc, tbl[i].pc, tbl[i].bub, tbl[i].fl, 1'b0,
                 tbl[i].fae, tbl[i].fbe, tbl[i].fai, tbl[i].fbi}));
    end
`ifdef HAZ_PERF_EN
    @(negedge clk);
    #1;
    check("perf_stall_trace", perf_stall, 32'd4);
    check("perf_flush_trace", perf_flush, 32'd2);
`endif

    // MEM_LAT=3: a load holds the pipe for exactly two cycles, redirect waits.
    do_reset();
    drive(mk(1, 1, 2, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // lw $2
    #1;
    check("hold_lw_in_id", 32'({u3_pc_en, u3_ifid_en, u3_idex_bubble, u3_ifid_flush,
                                u3_pipe_hold}), 32'(5'b11000));
    @(negedge clk);
    drive(mk(1, 1, 1, 1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // add $9,$1,$1
    #1;
    check("hold_lw_in_ex", 32'({u3_pc_en, u3_ifid_en, u3_idex_bubble, u3_ifid_flush,
                                u3_pipe_hold}), 32'(5'b11000));
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // j
    #1;
    check("hold_cycle1", 32'({u3_pc_en, u3_ifid_en, u3_idex_bubble, u3_ifid_flush,
                              u3_pipe_hold}), 32'(5'b00001));
    @(negedge clk);
    #1;
    check("hold_cycle2", 32'({u3_pc_en, u3_ifid_en, u3_idex_bubble, u3_ifid_flush,
                              u3_pipe_hold}), 32'(5'b00001));
    @(negedge clk);
    #1;
    check("hold_released", 32'({u3_pc_en, u3_ifid_en, u3_idex_bubble, u3_ifid_flush,
                                u3_pipe_hold}), 32'(5'b11010));

    // Reset during a hold drops it on the next cycle and empties every slot.
    do_reset();
    drive(mk(1, 1, 2, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // lw $2
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    check("rst_pre_hold", 32'(u3_pipe_hold), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(mk(1, 2, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // beq $2,$2
    #1;
    check("rst_mid_hold", 32'({u3_pc_en, u3_ifid_en, u3_idex_bubble, u3_ifid_flush,
                               u3_pipe_hold, u3_fwd_a_id, u3_fwd_b_id}), 32'(9'b110000000));
`ifdef HAZ_PERF_EN
    check("rst_perf_stall", u3_perf_stall, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
